mb_ascii_rx_deframer: RTL and testbench
=======================================

# mb_ascii_rx_deframer

Receive-side Modbus ASCII deframer. It takes received characters from the UART receiver, finds the ':' start, and converts hex character pairs into bytes. It accumulates the LRC over every decoded byte, including the transmitted LRC byte, and checks that the sum is zero when CR LF arrives. It sits between the UART RX character stream and the Modbus PDU handler, and is the checking counterpart of the transmit-side LRC generator.

## Interface
- MAX_BYTES, 256: maximum decoded bytes per frame, including the LRC byte.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_i  in  8  received ASCII character.
- char_valid_i  in  1  one-cycle strobe qualifying char_i; back-to-back allowed; no backpressure.
- abort_i  in  1  synchronous abort; returns to IDLE with no status pulse.
- byte_o  out  8  decoded data byte.
- byte_valid_o  out  1  one-cycle strobe qualifying byte_o; the LRC byte is never emitted.
- sof_o  out  1  one-cycle pulse; a new frame has started.
- frame_ok_o  out  1  one-cycle pulse; frame complete and LRC correct.
- frame_err_o  out  1  one-cycle pulse; frame ended with an error.
- err_code_o  out  3  last error cause; holds until the next sof_o.
- byte_cnt_o  out  $clog2(MAX_BYTES+1)  data bytes emitted in the current frame, excluding LRC.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, HI (expect high nibble), LO (expect low nibble), LF (CR received, expect LF).
- Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f'.
- IDLE: ignore every character except ':'.
  - On ':': clear sum, byte_cnt_o, pending_valid and err_code_o; pulse sof_o; go to HI.
- HI behaviour:
  - Hex digit: latch as high nibble; go to LO.
  - CR (0x0D): go to LF.
- LO behaviour:
  - Hex digit: completes byte b. Set sum <= sum + b (8-bit, wraps mod 256).
  - If pending_valid: emit the pending byte on byte_o/byte_valid_o and increment byte_cnt_o.
  - Then pending <= b, pending_valid <= 1, decoded count +1; go to HI.
  - CR: error 2 (odd nibble count).
- LF behaviour:
  - LF (0x0A), fewer than 2 decoded bytes: error 4 (short).
  - LF, sum != 0: error 5 (LRC mismatch).
  - LF, otherwise: pulse frame_ok_o; go to IDLE. The pending byte is the LRC and is discarded.
  - Any other character except ':': error 3 (no LF).
- ':' received in HI, LO or LF:
  - Error 7 (resync): pulse frame_err_o.
  - Restart as in IDLE: sof_o one cycle after frame_err_o, and err_code_o cleared at that point.
  - Go to HI.
- Any non-hex, non-CR, non-':' character in HI or LO: error 1 (bad char).
- A byte completing when the decoded count already equals MAX_BYTES: error 6 (overflow). That byte is neither accumulated nor emitted.
- Error handling (all codes except 7): set err_code_o, pulse frame_err_o, go to IDLE.
- Bytes already emitted are not retracted; the consumer discards them on frame_err_o.
- abort_i has priority over a simultaneous char_valid_i; that character is dropped.
- Error codes: 0 none, 1 bad char, 2 odd, 3 no LF, 4 short, 5 LRC, 6 overflow, 7 resync.

## Timing
- Reset values: state IDLE; byte_o 0x00; byte_cnt_o 0; err_code_o 0; all strobes and busy_o 0; sum 0; pending_valid 0.
- All outputs are registered.
- byte_valid_o asserts 1 cycle after the char_valid_i that carries the low nibble of the *following* byte. Each data byte therefore appears one byte later than it was decoded.
- sof_o, frame_ok_o and frame_err_o assert 1 cycle after the triggering character.
- frame_ok_o and frame_err_o never assert in the same cycle.
- byte_cnt_o is stable and final when frame_ok_o or frame_err_o pulses.
- Throughput: one character per cycle is sustained indefinitely.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; no status pulse.

## Test plan
- ":01030000000AF2\r\n":
  - byte_valid_o six times: 01, 03, 00, 00, 00, 0A.
  - frame_ok_o once; byte_cnt_o = 6; err_code_o = 0.
- Same frame with LRC "F3": the same six bytes are emitted, then frame_err_o with err_code_o = 5.
- Lowercase ":01030000000af2\r\n" sent back-to-back, every cycle: frame_ok_o. Expected result is identical to the first scenario.
- Malformed frames:
  - ":0103G0\r\n": err 1 at 'G', then the trailing characters are ignored.
  - ":010\r\n": err 2.
  - ":01\r\n": err 4.
  - ":01030\rX": err 2 at CR.
  - ":0103\rX": err 3.
- ":0103:01030000000AF2\r\n":
  - frame_err_o with err 7, followed by sof_o.
  - Then the six bytes and frame_ok_o, with err_code_o back at 0.
- Limits and interrupts:
  - MAX_BYTES = 4 with ":0102030405\r\n": err 6 on the fifth byte.
  - rst_n asserted mid-frame: no pulse occurs, and the next valid frame passes.
  - abort_i asserted mid-frame: no pulse occurs, and the next valid frame passes.

Source files
------------

// File: rtl/mb_ascii_rx_deframer.sv
// Modbus ASCII receive deframer: finds ':', pairs hex digits into bytes, checks the LRC at CR LF.
// Each data byte is held back one byte so the trailing LRC byte is never emitted.
module mb_ascii_rx_deframer #(
    parameter  int MAX_BYTES = 256,
    localparam int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    char_i,
    input  logic          char_valid_i,
    input  logic          abort_i,
    output logic [7:0]    byte_o,
    output logic          byte_valid_o,
    output logic          sof_o,
    output logic          frame_ok_o,
    output logic          frame_err_o,
    output logic [2:0]    err_code_o,
    output logic [CW-1:0] byte_cnt_o,
    output logic          busy_o
);

    // state | meaning
    // IDLE  | waiting for ':'
    // HI    | expecting high nibble (or CR)
    // LO    | expecting low nibble
    // LF    | CR seen, expecting LF
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_LF} state_t;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    state_t          r_state,     w_state_nxt;
    logic [3:0]      r_hi_nib,    w_hi_nib_nxt;
    logic [7:0]      r_sum,       w_sum_nxt;
    logic [7:0]      r_pend,      w_pend_nxt;
    logic            r_pend_v,    w_pend_v_nxt;
    logic [CW-1:0]   r_dec_cnt,   w_dec_cnt_nxt;
    logic            r_sof_pend,  w_sof_pend_nxt;
    logic [7:0]      r_byte,      w_byte_nxt;
    logic            r_byte_v,    w_byte_v_nxt;
    logic            r_sof,       w_sof_nxt;
    logic            r_ok,        w_ok_nxt;
    logic            r_err,       w_err_nxt;
    logic [2:0]      r_err_code,  w_err_code_nxt;
    logic [CW-1:0]   r_byte_cnt,  w_byte_cnt_nxt;

    logic            w_is_digit, w_is_upper, w_is_lower, w_is_hex;
    logic [3:0]      w_nib;
    logic [7:0]      w_byte_new;
    logic            w_fail;
    logic [2:0]      w_fail_code;

    assign w_is_digit = (char_i >= 8'h30) && (char_i <= 8'h39);
    assign w_is_upper = (char_i >= 8'h41) && (char_i <= 8'h46);
    assign w_is_lower = (char_i >= 8'h61) && (char_i <= 8'h66);
    assign w_is_hex   = w_is_digit || w_is_upper || w_is_lower;
    // 'A'/'a' have low nibble 1, so letters map to value by adding 9
    assign w_nib      = char_i[3:0] + (w_is_digit ? 4'd0 : 4'd9);
    assign w_byte_new = {r_hi_nib, w_nib};

    always_comb begin
        w_state_nxt    = r_state;
        w_hi_nib_nxt   = r_hi_nib;
        w_sum_nxt      = r_sum;
        w_pend_nxt     = r_pend;
        w_pend_v_nxt   = r_pend_v;
        w_dec_cnt_nxt  = r_dec_cnt;
        w_sof_pend_nxt = 1'b0;
        w_byte_nxt     = r_byte;
        w_byte_v_nxt   = 1'b0;
        w_sof_nxt      = 1'b0;
        w_ok_nxt       = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_byte_cnt_nxt = r_byte_cnt;
        w_fail         = 1'b0;
        w_fail_code    = 3'd0;

        // Delayed start after a resync: status of the killed frame was shown last cycle
        if (r_sof_pend && !abort_i) begin
            w_sof_nxt      = 1'b1;
            w_err_code_nxt = 3'd0;
            w_byte_cnt_nxt = '0;
        end

        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else if (char_valid_i) begin
            if (char_i == CH_COLON) begin
                if (r_state == S_IDLE) begin
                    w_sof_nxt      = 1'b1;
                    w_err_code_nxt = 3'd0;
                    w_byte_cnt_nxt = '0;
                end else begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 3'd7;
                    w_sof_pend_nxt = 1'b1;
                end
                w_sum_nxt     = 8'h00;
                w_dec_cnt_nxt = '0;
                w_pend_v_nxt  = 1'b0;
                w_state_nxt   = S_HI;
            end else begin
                case (r_state)
                    S_HI: begin
                        if (w_is_hex) begin
                            w_hi_nib_nxt = w_nib;
                            w_state_nxt  = S_LO;
                        end else if (char_i == CH_CR) begin
                            w_state_nxt = S_LF;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd1;
                        end
                    end
                    S_LO: begin
                        if (w_is_hex) begin
                            if (r_dec_cnt == CW'(MAX_BYTES)) begin
                                w_fail      = 1'b1;
                                w_fail_code = 3'd6;
                            end else begin
                                w_sum_nxt = r_sum + w_byte_new;
                                if (r_pend_v) begin
                                    w_byte_nxt     = r_pend;
                                    w_byte_v_nxt   = 1'b1;
                                    w_byte_cnt_nxt = r_byte_cnt + CW'(1);
                                end
                                w_pend_nxt    = w_byte_new;
                                w_pend_v_nxt  = 1'b1;
                                w_dec_cnt_nxt = r_dec_cnt + CW'(1);
                                w_state_nxt   = S_HI;
                            end
                        end else if (char_i == CH_CR) begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd2;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd1;
                        end
                    end
                    S_LF: begin
                        if (char_i == CH_LF) begin
                            if (r_dec_cnt < CW'(2)) begin
                                w_fail      = 1'b1;
                                w_fail_code = 3'd4;
                            end else if (r_sum != 8'h00) begin
                                w_fail      = 1'b1;
                                w_fail_code = 3'd5;
                            end else begin
                                w_ok_nxt    = 1'b1;
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd3;
                        end
                    end
                    default: ;
                endcase
                if (w_fail) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_fail_code;
                    w_state_nxt    = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hi_nib   <= 4'h0;
            r_sum      <= 8'h00;
            r_pend     <= 8'h00;
            r_pend_v   <= 1'b0;
            r_dec_cnt  <= '0;
            r_sof_pend <= 1'b0;
            r_byte     <= 8'h00;
            r_byte_v   <= 1'b0;
            r_sof      <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hi_nib   <= w_hi_nib_nxt;
            r_sum      <= w_sum_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_dec_cnt  <= w_dec_cnt_nxt;
            r_sof_pend <= w_sof_pend_nxt;
            r_byte     <= w_byte_nxt;
            r_byte_v   <= w_byte_v_nxt;
            r_sof      <= w_sof_nxt;
            r_ok       <= w_ok_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

    assign byte_o       = r_byte;
    assign byte_valid_o = r_byte_v;
    assign sof_o        = r_sof;
    assign frame_ok_o   = r_ok;
    assign frame_err_o  = r_err;
    assign err_code_o   = r_err_code;
    assign byte_cnt_o   = r_byte_cnt;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mb_ascii_rx_deframer.sv
// Bench for mb_ascii_rx_deframer: two instances (MAX_BYTES 256 and 4) share one character stream
// and their output events are compared against a frame-level parse of the stream.
module tb_mb_ascii_rx_deframer;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_i = 8'h00;
    logic       char_valid_i = 1'b0;
    logic       abort_i = 1'b0;

    logic [7:0] byte0, byte4;
    logic       bv0, sof0, ok0, err0, busy0;
    logic       bv4, sof4, ok4, err4, busy4;
    logic [2:0] ec0, ec4;
    logic [8:0] cnt0;
    logic [2:0] cnt4;

    mb_ascii_rx_deframer u_dut (
        .clk(clk), .rst_n(rst_n), .char_i(char_i), .char_valid_i(char_valid_i), .abort_i(abort_i),
        .byte_o(byte0), .byte_valid_o(bv0), .sof_o(sof0), .frame_ok_o(ok0), .frame_err_o(err0),
        .err_code_o(ec0), .byte_cnt_o(cnt0), .busy_o(busy0)
    );

    mb_ascii_rx_deframer #(.MAX_BYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .char_i(char_i), .char_valid_i(char_valid_i), .abort_i(abort_i),
        .byte_o(byte4), .byte_valid_o(bv4), .sof_o(sof4), .frame_ok_o(ok4), .frame_err_o(err4),
        .err_code_o(ec4), .byte_cnt_o(cnt4), .busy_o(busy4)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   first_char_cyc, last_char_cyc, sof_cyc, done_cyc;
    iq_t  obs0, obs1, exp0, exp1;
    string CRLF = "\015\012";

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_hex(input byte unsigned c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic int hexv(input byte unsigned c);
        if (c <= 8'h39) return int'(c) - 48;
        if (c <= 8'h46) return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic int outc(input bit ok, input int code, input int cnt);
        return (ok ? 32'h10000 : 32'h20000) | (code << 12) | cnt;
    endfunction

    // Output events seen in one cycle, in sof / byte / status order
    function automatic iq_t ev(input logic sof, input logic bv, input logic [7:0] b, input logic ok,
                               input logic err, input logic [2:0] ec, input int cnt);
        iq_t q;
        if (sof) q.push_back(32'h200 | (int'(ec) << 4) | ((cnt != 0) ? 1 : 0));
        if (bv) q.push_back(32'h100 | int'(b));
        if (ok && err) q.push_back(32'hDEAD);
        else if (ok) q.push_back(outc(1'b1, int'(ec), cnt));
        else if (err) q.push_back(outc(1'b0, int'(ec), cnt));
        return q;
    endfunction

    // Frame-level parse of a character stream into the expected event list
    function automatic iq_t model(input string s, input int maxb);
        iq_t q;
        byte unsigned bs[$];
        byte unsigned c, c2;
        int n, i, j, nd, nb, sum, cnt, hi;
        bit ovf;
        n = s.len();
        i = 0;
        while (i < n) begin
            if (s[i] != 8'h3A) begin
                i++;
                continue;
            end
            q.push_back(32'h200);
            j = i + 1; nd = 0; hi = 0; ovf = 1'b0;
            bs.delete();
            while (j < n && !ovf && is_hex(s[j])) begin
                if (nd % 2 == 0) hi = hexv(s[j]);
                else if (bs.size() == maxb) ovf = 1'b1;
                else bs.push_back(8'(hi * 16 + hexv(s[j])));
                nd++;
                j++;
            end
            nb = bs.size();
            cnt = (nb > 0) ? nb - 1 : 0;
            for (int k = 0; k < nb - 1; k++) q.push_back(32'h100 | int'(bs[k]));
            if (ovf) begin
                q.push_back(outc(1'b0, 6, cnt));
                i = j;
                continue;
            end
            if (j >= n) break;
            c = s[j];
            if (c == 8'h3A) begin
                q.push_back(outc(1'b0, 7, cnt));
                i = j;
            end else if (c == 8'h0D) begin
                if (nd % 2 == 1) begin
                    q.push_back(outc(1'b0, 2, cnt));
                    i = j + 1;
                end else if (j + 1 >= n) begin
                    break;
                end else begin
                    c2 = s[j + 1];
                    if (c2 == 8'h0A) begin
                        sum = 0;
                        foreach (bs[m]) sum += int'(bs[m]);
                        if (nb < 2) q.push_back(outc(1'b0, 4, cnt));
                        else if (sum % 256 != 0) q.push_back(outc(1'b0, 5, cnt));
                        else q.push_back(outc(1'b1, 0, cnt));
                        i = j + 2;
                    end else if (c2 == 8'h3A) begin
                        q.push_back(outc(1'b0, 7, cnt));
                        i = j + 1;
                    end else begin
                        q.push_back(outc(1'b0, 3, cnt));
                        i = j + 2;
                    end
                end
            end else begin
                q.push_back(outc(1'b0, 1, cnt));
                i = j + 1;
            end
        end
        return q;
    endfunction

    always @(negedge clk) begin
        obs0 = {obs0, ev(sof0, bv0, byte0, ok0, err0, ec0, int'(cnt0))};
        obs1 = {obs1, ev(sof4, bv4, byte4, ok4, err4, ec4, int'(cnt4))};
        if (sof0) sof_cyc = cyc;
        if (ok0 || err0) done_cyc = cyc;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string s, input int maxgap);
        int g;
        for (int k = 0; k < s.len(); k++) begin
            @(negedge clk);
            char_i = s[k];
            char_valid_i = 1'b1;
            last_char_cyc = cyc + 1;
            if (k == 0) first_char_cyc = cyc + 1;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (g > 0) begin
                @(negedge clk);
                char_valid_i = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        char_valid_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string s, input int maxgap);
        exp0 = {exp0, model(s, 256)};
        exp1 = {exp1, model(s, 4)};
        send(s, maxgap);
    endtask

    task automatic compare(input string tag);
        #1;
        chk({tag, "_n256"}, obs0.size(), exp0.size());
        for (int k = 0; k < exp0.size() && k < obs0.size(); k++)
            chk($sformatf("%s_d256_ev%0d", tag, k), obs0[k], exp0[k]);
        chk({tag, "_n4"}, obs1.size(), exp1.size());
        for (int k = 0; k < exp1.size() && k < obs1.size(); k++)
            chk($sformatf("%s_d4_ev%0d", tag, k), obs1[k], exp1[k]);
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte"}, int'(byte0), 0);
        chk({tag, "_cnt"}, int'(cnt0), 0);
        chk({tag, "_ec"}, int'(ec0), 0);
        chk({tag, "_strobes"}, int'({bv0, sof0, ok0, err0, busy0}), 0);
        chk({tag, "_d4"}, int'({byte4, cnt4, ec4, bv4, sof4, ok4, err4, busy4}), 0);
    endtask

    function automatic string hx(input int v);
        return ($urandom_range(1, 0) == 1) ? $sformatf("%02X", v) : $sformatf("%02x", v);
    endfunction

    string f1, bad_s[5], rs, noise;
    int    bad_c[5];
    int    len, sum, v, lrc, corrupt;

    initial begin
        f1 = {":01030000000AF2", CRLF};
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run(f1, 0);
        chk("f1_cnt", int'(cnt0), 6);
        chk("f1_ec", int'(ec0), 0);
        chk("f1_busy", int'(busy0), 0);
        chk("f1_sof_lat", sof_cyc, first_char_cyc);
        chk("f1_ok_lat", done_cyc, last_char_cyc);
        chk("f1_d4_ec", int'(ec4), 6);
        chk("f1_d4_cnt", int'(cnt4), 3);
        compare("f1");

        run({":01030000000AF3", CRLF}, 0);
        chk("lrc_ec", int'(ec0), 5);
        chk("lrc_cnt", int'(cnt0), 6);
        compare("lrc");

        run({":01030000000af2", CRLF}, 0);
        chk("lc_ec", int'(ec0), 0);
        chk("lc_cnt", int'(cnt0), 6);
        compare("lc");

        bad_s[0] = {":0103G0", CRLF};   bad_c[0] = 1;
        bad_s[1] = {":010", CRLF};      bad_c[1] = 2;
        bad_s[2] = {":01", CRLF};       bad_c[2] = 4;
        bad_s[3] = ":01030\015X";       bad_c[3] = 2;
        bad_s[4] = ":0103\015X";        bad_c[4] = 3;
        for (int k = 0; k < 5; k++) begin
            run(bad_s[k], 0);
            chk($sformatf("bad%0d_ec", k), int'(ec0), bad_c[k]);
            chk($sformatf("bad%0d_busy", k), int'(busy0), 0);
            compare($sformatf("bad%0d", k));
        end

        run({":0103:01030000000AF2", CRLF}, 0);
        chk("resync_ec", int'(ec0), 0);
        chk("resync_cnt", int'(cnt0), 6);
        compare("resync");

        run({":0102030405", CRLF}, 0);
        chk("ovf_d4_ec", int'(ec4), 6);
        chk("ovf_d4_cnt", int'(cnt4), 3);
        chk("ovf_d256_ec", int'(ec0), 5);
        compare("ovf");

        run(":01030", 0);
        chk("mid_busy", int'(busy0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compare("midrst");
        run(f1, 0);
        chk("postrst_ec", int'(ec0), 0);
        compare("postrst");

        run(":0103", 0);
        chk("abort_busy_pre", int'(busy0), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy0), 0);
        abort_i = 1'b1;
        char_i = 8'h3A;
        char_valid_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        char_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_colon_busy", int'(busy0), 0);
        compare("abort");
        run(f1, 0);
        chk("postabort_ec", int'(ec0), 0);
        compare("postabort");

        noise = "xZ !q\015\012";
        rs = "";
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(2, 0)) rs = {rs, $sformatf("%c", noise[$urandom_range(6, 0)])};
            rs = {rs, ":"};
            len = $urandom_range(8, 0);
            corrupt = $urandom_range(7, 0);
            sum = 0;
            for (int b = 0; b < len; b++) begin
                v = $urandom_range(255, 0);
                sum += v;
                rs = {rs, hx(v)};
                if (corrupt == 1 && b == len / 2) rs = {rs, ":"};
            end
            lrc = (256 - (sum % 256)) % 256;
            if (corrupt == 2) lrc = (lrc + 1) % 256;
            rs = {rs, hx(lrc)};
            if (corrupt == 3) rs = {rs, "G"};
            if (corrupt == 4) rs = {rs, "\015"};
            else rs = {rs, CRLF};
        end
        rs = {rs, "x"};
        run(rs, 2);
        chk("rand_busy", int'(busy0), 0);
        compare("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
